// File: rtl/vga_timing_engine.sv
// vga_timing_engine: VGA raster counters, sync decode and latency-matched DAC output stage
module vga_timing_engine #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3*COLOR_W-1:0] color_in,
    output logic [CNT_W-1:0]     next_x,
    output logic [CNT_W-1:0]     next_y,
    output logic                 next_valid,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 hsync,
    output logic                 vsync,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 blank_n,
    output logic                 sync_n,
    output logic                 clk
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FRONT + V_PULSE);
    localparam logic [2:0]       IDLE    = {1'b0, ~HS_POL, ~VS_POL};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic raw_act, raw_hs, raw_vs;
    logic d_act, d_hs, d_vs;

    function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[7-i] = c[COLOR_W-1-(i%COLOR_W)];
        return e;
    endfunction

    // Pixel counter wraps every line; line counter advances (and wraps) on that same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
            if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Raw timing decode straight from the counters
    always_comb begin
        raw_act = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        raw_hs  = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
        raw_vs  = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
    end

    assign next_valid  = raw_act;
    assign next_x      = raw_act ? h_cnt : '0;
    assign next_y      = raw_act ? v_cnt : '0;
    assign line_start  = ~reset && (h_cnt == '0) && (v_cnt < V_VIS);
    assign frame_start = ~reset && (h_cnt == '0) && (v_cnt == '0);
    assign sync_n      = 1'b0;
    assign clk         = clock;

    generate
        if (PIPE_LAT > 0) begin : g_dly
            logic [2:0] dly [PIPE_LAT];
            // Delay timing by the pixel source read latency so sync stays aligned with color
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_LAT; i++) dly[i] <= IDLE;
                end else begin
                    dly[0] <= {raw_act, raw_hs, raw_vs};
                    for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
                end
            end
            assign {d_act, d_hs, d_vs} = dly[PIPE_LAT-1];
        end else begin : g_nodly
            assign {d_act, d_hs, d_vs} = {raw_act, raw_hs, raw_vs};
        end
    endgenerate

    // Output register: syncs, blanking and 8-bit expanded color, black outside the visible area
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync   <= ~HS_POL;
            vsync   <= ~VS_POL;
            blank_n <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            hsync   <= d_hs;
            vsync   <= d_vs;
            blank_n <= d_act;
            red     <= d_act ? expand(color_in[3*COLOR_W-1 -: COLOR_W]) : 8'h00;
            green   <= d_act ? expand(color_in[2*COLOR_W-1 -: COLOR_W]) : 8'h00;
            blue    <= d_act ? expand(color_in[COLOR_W-1:0]) : 8'h00;
        end
    end
endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 The block SHALL have the following parameters, given as name, default, meaning:
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in cycles.
- H_PULSE, 96, hsync width in cycles.
- H_BACK, 48, horizontal back porch in cycles.
- V_ACTIVE, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_PULSE, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- HS_POL, 0, hsync asserted level.
- VS_POL, 0, vsync asserted level.
- COLOR_W, 4, input bits per channel (1..8).
- PIPE_LAT, 2, pixel-source read latency in cycles (0..15).
- CNT_W, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.

REQ-002 Porch and pulse parameters are true counts, not count-1. H_TOTAL = H_ACTIVE+H_FRONT+H_PULSE+H_BACK. V_TOTAL is the vertical equivalent.

REQ-003 The block SHALL have the following ports, given as name, direction, width, meaning:
- clock, in, 1, pixel clock. This is the only clock.
- reset, in, 1, asynchronous, active-high reset.
- color_in, in, 3*COLOR_W, pixel {R,G,B}, R in the MSBs.
- next_x, out, CNT_W, requested pixel column.
- next_y, out, CNT_W, requested pixel row.
- next_valid, out, 1, high when next_x/next_y is a visible pixel.
- line_start, out, 1, one-cycle pulse at the start of each visible line.
- frame_start, out, 1, one-cycle pulse at the start of each frame.
- hsync, out, 1, horizontal sync to the connector.
- vsync, out, 1, vertical sync to the connector.
- red, out, 8, DAC red.
- green, out, 8, DAC green.
- blue, out, 8, DAC blue.
- blank_n, out, 1, high during visible output.
- sync_n, out, 1, constant 0.
- clk, out, 1, equal to clock.

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 every cycle and wrap to 0.

REQ-005 v_cnt SHALL increment in the cycle h_cnt wraps. v_cnt SHALL wrap from V_TOTAL-1 to 0 in that same cycle.

REQ-006 Raw video-active SHALL be (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).

REQ-007 Raw hsync SHALL equal HS_POL while H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_PULSE, and ~HS_POL otherwise.

REQ-008 Raw vsync SHALL equal VS_POL while V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_PULSE, and ~VS_POL otherwise. Vsync transitions SHALL occur only on line boundaries (h_cnt==0).

REQ-009 next_x, next_y and next_valid SHALL be combinational from the counters:
- next_valid = raw active.
- next_x = h_cnt when next_valid, else 0.
- next_y = v_cnt when next_valid, else 0.

REQ-010 line_start SHALL be high exactly when h_cnt==0 and v_cnt<V_ACTIVE.

REQ-011 frame_start SHALL be high exactly when h_cnt==0 and v_cnt==0. It SHALL coincide with the line_start of row 0.

REQ-012 The pixel source presents color_in exactly PIPE_LAT cycles after the cycle in which it saw next_x/next_y with next_valid high.

REQ-013 Raw active, raw hsync and raw vsync SHALL pass through a PIPE_LAT-stage delay line followed by one output register. Total latency from counter position to hsync/vsync/blank_n is PIPE_LAT+1 cycles.

REQ-014 color_in SHALL be registered in the same output stage. In that stage:
- If delayed active is high, each channel is expanded to 8 bits by MSB-first bit replication (e.g. COLOR_W=4 gives {c,c}; COLOR_W=3 gives {c,c,c[2:1]}).
- If delayed active is low, red, green and blue SHALL all be 0.

REQ-015 blank_n SHALL equal registered delayed active. red/green/blue SHALL be nonzero only while blank_n is high.

REQ-016 With PIPE_LAT=0, color_in is sampled in the same cycle next_valid is high and appears on the DAC outputs 1 cycle later.

REQ-017 The last visible pixel (H_ACTIVE-1, V_ACTIVE-1) SHALL be followed by h_cnt=H_ACTIVE with v_cnt unchanged. No extra pixel and no dropped pixel is permitted at any line or frame wrap.

Reset
REQ-018 While reset is high, the following SHALL hold asynchronously:
- h_cnt and v_cnt are 0.
- All delay stages are inactive, meaning active=0, hsync=~HS_POL, vsync=~VS_POL.
- red, green and blue are 0.
- blank_n is 0.
- hsync is ~HS_POL and vsync is ~VS_POL.
- line_start and frame_start are 0 (combinational gating by reset).

REQ-019 On the first clock edge after reset deasserts, the counters SHALL be at (0,0) with frame_start high. A frame restarts cleanly even if reset was asserted mid-line or mid-pulse.

Verification
REQ-020 The bench SHALL use a small config: H=8/2/3/2 (H_TOTAL=15), V=4/1/2/1 (V_TOTAL=8), PIPE_LAT=2, COLOR_W=4. It SHALL cover these scenarios:
- Free-run 3 frames → hsync period is 15 cycles and low for 3; vsync is low for 2 lines (30 cycles); frame_start period is 120 cycles.
- Pixel source returns color_in={x[3:0],y[3:0],4'hA} with latency 2 → at (5,3), red=8'h55, green=8'h33, blue=8'hAA, appearing 3 cycles after next_x=5,next_y=3; DAC outputs are 0 in all porch/pulse cycles.
- Counter wrap → after (7,3), next_valid is low for 7 cycles, then row 4..7 stays invalid; frame_start coincides with the (0,0) request; there are exactly 32 next_valid cycles per frame.
- Reset pulse asserted mid-vsync (async, between edges) → hsync/vsync go immediately to 1 and blank_n to 0; after release, frame_start occurs on the first edge.
- HS_POL=1, VS_POL=1, PIPE_LAT=0 → sync pulses are high-true, idle low during reset; RGB lags next_x by 1 cycle.
